// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller for one-byte transactions
// (START, 7-bit address + R/W, one data byte, STOP).
// SCL is derived from clk: each bit cell is four quarters of CLK_DIV clocks.
// SDA and SCL are open-drain: each line is either pulled low or released.
// Optional macro I2C_CLK_STRETCH_EN: when defined, the quarter counter
// holds during Q2 while the scl line still reads low (slave clock stretch).
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  inout  logic       sda,
  inout  logic       scl
);

  localparam logic [7:0] Q_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_NACK,
    STOP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  q_cnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  data_q;
  logic        rw_q;
  logic        sda_low;
  logic        scl_low;
  logic        hold;
  logic        q_last;
  logic        sample;
  logic        cell_end;
  logic        accept;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = (phase == 2'd2) && (scl == 1'b0);
`else
  assign hold = 1'b0;
`endif

  assign q_last   = (q_cnt == Q_MAX);
  assign sample   = (phase == 2'd2) && q_last && !hold;
  assign cell_end = (phase == 2'd3) && q_last;
  // busy already covers the done cycle, so a start coinciding with done is ignored
  assign accept   = (state == IDLE) && start && !busy;

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic: transitions happen only at bit-cell boundaries
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = START;
      START:    if (cell_end) state_n = ADDR;
      ADDR:     if (cell_end && bit_cnt == 3'd0) state_n = ADDR_ACK;
      ADDR_ACK: if (cell_end) state_n = ack_err ? STOP : (rw_q ? READ : WRITE);
      WRITE:    if (cell_end && bit_cnt == 3'd0) state_n = WR_ACK;
      WR_ACK:   if (cell_end) state_n = STOP;
      READ:     if (cell_end && bit_cnt == 3'd0) state_n = RD_NACK;
      RD_NACK:  if (cell_end) state_n = STOP;
      STOP:     if (cell_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Line drive and busy flag decoded from state and quarter phase
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    busy    = (state != IDLE) || done;
    case (state)
      START: sda_low = phase[1];
      ADDR, WRITE: begin
        scl_low = ~phase[1];
        sda_low = ~shreg[7];
      end
      ADDR_ACK, WR_ACK, READ, RD_NACK: scl_low = ~phase[1];
      STOP: begin
        scl_low = (phase == 2'd0);
        sda_low = ~phase[1];
      end
      default: ;
    endcase
  end

  // Quarter timing, bit counter, shift registers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      data_rd <= '0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state == IDLE) begin
        q_cnt <= '0;
        phase <= '0;
      end else if (!hold) begin
        if (q_last) begin
          q_cnt <= '0;
          phase <= phase + 2'd1;
        end else begin
          q_cnt <= q_cnt + 8'd1;
        end
      end

      if (accept) begin
        shreg   <= {addr, rw};
        rw_q    <= rw;
        data_q  <= data_wr;
        ack_err <= 1'b0;
      end

      if (sample) begin
        case (state)
          ADDR_ACK, WR_ACK: if (sda) ack_err <= 1'b1;
          READ:             data_rd <= {data_rd[6:0], sda};
          default: ;
        endcase
      end

      if (cell_end) begin
        case (state)
          START: bit_cnt <= 3'd7;
          ADDR, WRITE, READ: begin
            bit_cnt <= bit_cnt - 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
          // reload for whichever byte phase follows the address ACK
          ADDR_ACK: begin
            bit_cnt <= 3'd7;
            shreg   <= data_q;
          end
          STOP: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural slave at
// address 7'h72 on a pulled-up open-drain bus, a bus event monitor and a
// scoreboard that checks each completed transaction when done pulses.
module tb_i2c_master;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       done;
  logic       ack_err;
  logic       busy;
  wire        sda;
  wire        scl;

  pullup (sda);
  pullup (scl);

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .done    (done),
    .ack_err (ack_err),
    .busy    (busy),
    .sda     (sda),
    .scl     (scl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- slave model and bus monitor ----------------
  typedef enum int {SL_IDLE, SL_ADDR, SL_AACK, SL_WDATA, SL_WACK, SL_RDATA, SL_RNACK, SL_IGN} sl_t;
  sl_t        sl_st = SL_IDLE;
  logic       slv_drive = 1'b0;
  logic [7:0] sl_sr = '0;
  logic [7:0] slave_data_in = '0;
  logic [7:0] slave_tx = 8'hB3;
  int         sl_bits = 0;
  logic       sl_rw = 1'b0;
  logic       p_sda = 1'b1;
  logic       p_scl = 1'b1;
  int         bus_starts = 0;
  int         bus_stops = 0;
  int         bus_order_err = 0;
  int         bus_rises = 0;
  int         nack_cnt = 0;

  assign sda = slv_drive ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic c_sda;
    logic c_scl;
    c_sda = (sda === 1'b1);
    c_scl = (scl === 1'b1);
    if (c_scl && p_scl && p_sda && !c_sda) begin
      bus_starts++;
      sl_st = SL_ADDR; sl_bits = 0; sl_sr = '0; slv_drive = 1'b0;
    end else if (c_scl && p_scl && !p_sda && c_sda) begin
      if (bus_stops >= bus_starts) bus_order_err++;
      bus_stops++;
      sl_st = SL_IDLE; slv_drive = 1'b0;
    end else if (c_scl && !p_scl) begin
      bus_rises++;
      case (sl_st)
        SL_ADDR, SL_WDATA: begin sl_sr = {sl_sr[6:0], c_sda}; sl_bits++; end
        SL_RDATA: sl_bits++;
        SL_RNACK: if (c_sda) nack_cnt++;
        default: ;
      endcase
    end else if (!c_scl && p_scl) begin
      case (sl_st)
        SL_ADDR: if (sl_bits == 8) begin
          if (sl_sr[7:1] == 7'h72) begin
            slv_drive = 1'b1; sl_rw = sl_sr[0]; sl_st = SL_AACK;
          end else sl_st = SL_IGN;
        end
        SL_AACK: begin
          sl_bits = 0;
          if (sl_rw) begin sl_st = SL_RDATA; slv_drive = ~slave_tx[7]; end
          else begin sl_st = SL_WDATA; slv_drive = 1'b0; sl_sr = '0; end
        end
        SL_WDATA: if (sl_bits == 8) begin
          slave_data_in = sl_sr; slv_drive = 1'b1; sl_st = SL_WACK;
        end
        SL_WACK: begin slv_drive = 1'b0; sl_st = SL_IGN; end
        SL_RDATA: if (sl_bits == 8) begin slv_drive = 1'b0; sl_st = SL_RNACK; end
                  else slv_drive = ~slave_tx[7 - sl_bits];
        default: ;
      endcase
    end
    p_sda = c_sda;
    p_scl = c_scl;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       chk_rd;
    logic [7:0] rd;
    logic       ack;
    logic       chk_wr;
    logic [7:0] wr;
    int         rises;
    logic       chk_nack;
    int         b_rises;
    int         b_starts;
    int         b_stops;
    int         b_nack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic expect_txn(input logic chk_rd, input logic [7:0] rd, input logic ack,
                            input logic chk_wr, input logic [7:0] wr, input int rises,
                            input logic chk_nack);
    exp_t e;
    e.chk_rd = chk_rd; e.rd = rd; e.ack = ack; e.chk_wr = chk_wr; e.wr = wr;
    e.rises = rises; e.chk_nack = chk_nack;
    e.b_rises = bus_rises; e.b_starts = bus_starts; e.b_stops = bus_stops; e.b_nack = nack_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_err", int'(ack_err), int'(mon_e.ack));
        if (mon_e.chk_rd) check("data_rd", int'(data_rd), int'(mon_e.rd));
        if (mon_e.chk_wr) check("slave_data_in", int'(slave_data_in), int'(mon_e.wr));
        check("scl_rises", bus_rises - mon_e.b_rises, mon_e.rises);
        check("bus_start_cnt", bus_starts - mon_e.b_starts, 1);
        check("bus_stop_cnt", bus_stops - mon_e.b_stops, 1);
        check("bus_order_err", bus_order_err, 0);
        if (mon_e.chk_nack) check("master_nack", nack_cnt - mon_e.b_nack, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; data_wr = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done with a cycle budget; optionally injects a start while busy
  // (inj_at) or holds a fresh start across the done cycle (chain).
  task automatic wait_done(input string name, input int exp_lat, input int inj_at, input bit chain);
    int cyc = 0;
    int low_busy = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy !== 1'b1) low_busy++;
      start = (cyc == inj_at);
      if (cyc == inj_at) begin addr = 7'h15; rw = 1'b1; data_wr = 8'hFF; end
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_busy_hold"}, low_busy, 0);
    if (chain) begin
      slave_tx = 8'h4E;
      expect_txn(1'b1, 8'h4E, 1'b0, 1'b0, 8'h00, 19, 1'b1);
      addr = 7'h72; rw = 1'b1; data_wr = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      check({name, "_done_cycle_start_ignored"}, int'(busy), 0);
      check({name, "_done_width"}, int'(done), 0);
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_next_start_accepted"}, int'(busy), 1);
    end else begin
      start = 1'b0;
      @(posedge clk); #1;
      check({name, "_done_width"}, int'(done), 0);
      check({name, "_busy_clear"}, int'(busy), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    rst_n = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; data_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_rd", int'(data_rd), 0);
    check("rst_done", int'(done), 0);
    check("rst_ack_err", int'(ack_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sda_released", int'(sda === 1'b1), 1);
    check("rst_scl_released", int'(scl === 1'b1), 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // write 0xA5: 20 cells * 16 clk
    expect_txn(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 19, 1'b0);
    issue(7'h72, 1'b0, 8'hA5);
    wait_done("write", 320, -1, 1'b0);

    // read 0xB3, answered with NACK
    slave_tx = 8'hB3;
    expect_txn(1'b1, 8'hB3, 1'b0, 1'b0, 8'h00, 19, 1'b1);
    issue(7'h72, 1'b1, 8'h00);
    wait_done("read", 320, -1, 1'b0);

    // bad address: START + 9 cells + STOP, slave byte untouched
    expect_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 10, 1'b0);
    issue(7'h15, 1'b0, 8'h11);
    wait_done("bad_addr", 176, -1, 1'b0);
    check("ack_err_held", int'(ack_err), 1);

    // start while busy (during ADDR) is ignored
    expect_txn(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 19, 1'b0);
    issue(7'h72, 1'b0, 8'h3C);
    check("ack_err_cleared_on_accept", int'(ack_err), 0);
    wait_done("busy_start", 320, 40, 1'b0);

    // start held across done: ignored in done cycle, accepted next cycle
    expect_txn(1'b0, 8'h00, 1'b0, 1'b1, 8'h96, 19, 1'b0);
    issue(7'h72, 1'b0, 8'h96);
    wait_done("chain_write", 320, -1, 1'b1);
    wait_done("chain_read", 320, -1, 1'b0);

    // reset during WRITE bit 3 (cell 14, Q0: both lines low)
    issue(7'h72, 1'b0, 8'hA5);
    repeat (226) @(posedge clk);
    #1;
    check("pre_reset_sda_low", int'(sda === 1'b0), 1);
    check("pre_reset_scl_low", int'(scl === 1'b0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_sda_released", int'(sda === 1'b1), 1);
    check("mid_reset_scl_released", int'(scl === 1'b1), 1);
    check("mid_reset_busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    expect_txn(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 19, 1'b0);
    issue(7'h72, 1'b0, 8'hC3);
    wait_done("post_reset_write", 320, -1, 1'b0);

    drain = 0;
    while (sb.size() != 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
